fsk_shift_clock: RTL and testbench
==================================

Name: fsk_shift_clock

Overview:
- Gated square-wave shift-clock generator for the backscatter modulator; a parametrised successor to the fixed half-period gated divider.
- Runtime-programmable half-period with two tone registers for FSK.
- Tone changes take effect only on a toggle boundary, so the output is glitch-free and phase-continuous.
- On trigger de-assertion the block completes the current high phase instead of truncating it; it sits between the packet/bit sequencer and the RF switch driver.

Parameters:
- CNT_W, 12, counter and half-period width (max half-period 2^CNT_W cycles).
- IDLE_LEVEL, 0, value of clock_out in IDLE and after reset (1-bit).

Ports:
- clock_in  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- trigger_signal  in  1  run request; high = generate, low = stop at next low phase.
- tone_sel  in  1  selects half_period_0 (0) or half_period_1 (1); sampled only at latch points.
- half_period_0  in  CNT_W  tone-0 terminal count; half-period = value+1 cycles.
- half_period_1  in  CNT_W  tone-1 terminal count.
- clock_out  out  1  generated shift clock.
- toggle_strobe  out  1  one-cycle pulse, high in the cycle clock_out has just changed.
- tone_active  out  1  tone currently in force.
- busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset (async, while high): state=IDLE, counter=0, limit=0, clock_out=IDLE_LEVEL, toggle_strobe=0, tone_active=0, busy=0.
- States are IDLE, RUN and DRAIN.
- IDLE:
  - counter held at 0 and clock_out=IDLE_LEVEL.
  - trigger high: next state RUN, counter<=0, limit<=selected half_period, tone_active<=tone_sel.
- RUN:
  - counter!=limit: counter<=counter+1.
  - counter==limit: counter<=0, clock_out toggles, toggle_strobe=1 next cycle, limit and tone_active re-latched from tone_sel/half_period_x (latch point).
  - First toggle is limit+2 edges after the edge that sampled trigger high in IDLE. Output period is 2*(limit+1) cycles.
  - trigger low with clock_out==IDLE_LEVEL: go to IDLE the next cycle and clear the counter.
  - trigger low with clock_out!=IDLE_LEVEL: go to DRAIN; counter continues.
- DRAIN:
  - Counts with the frozen limit; tone_sel and half_period inputs are ignored.
  - On the toggle back to IDLE_LEVEL: go to IDLE with counter=0.
  - trigger re-asserted: return to RUN with counter and clock_out untouched (phase-continuous).
- Boundary conditions:
  - limit=0: clock_out toggles every cycle (clock_in/2).
  - limit=2^CNT_W-1: counter reaches all-ones, then wraps to 0 only through the terminal compare, never by overflow.
  - half_period changes mid-phase: no effect until the next latch point.
  - Simultaneous terminal count and trigger low: the toggle happens. If the result is IDLE_LEVEL, go to IDLE; otherwise go to DRAIN.
  - Reset mid-operation: immediate return to reset values; no partial pulse completion.
- busy = (state!=IDLE), registered.

Optional Feature:
- Macro FSK_TRIGGER_SYNC_EN.
- Defined: trigger_signal and tone_sel each pass through a 2-flop synchroniser (reset to 0) before use. All trigger-to-output latencies grow by 2 cycles.
- Undefined: inputs are used directly; they must be synchronous to clock_in.

Decomposition:
- Shared package fsk_clk_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - the CNT_W default constant;
  - the IDLE_LEVEL default.
- One sub-module, trigger_sync (2-flop synchroniser, async active-high reset), instantiated only under FSK_TRIGGER_SYNC_EN.

Test Plan:
- Reset asserted mid-RUN, clock_out=1 -> clock_out=0, busy=0, counter=0 within the same cycle (async); after release, stays IDLE until trigger.
- half_period_0=319, tone_sel=0, trigger held -> first rise 321 edges after trigger sample; then period 640 cycles, 50% duty, toggle_strobe every 320 cycles.
- tone_sel 0->1 (half_period_1=159) mid-phase -> current half-phase completes at 320 cycles; subsequent half-phases are 160; tone_active switches with that toggle; no runt pulse.
- Trigger dropped 10 cycles into a high phase (limit=319) -> busy stays high and clock_out falls 310 cycles later; then IDLE, busy=0.
- In DRAIN, trigger re-asserted after 50 cycles -> no phase discontinuity; toggles continue on the 320-cycle grid.
- half_period_0=0 -> clock_out toggles every cycle; toggle_strobe held high continuously while RUN.

Source files
------------

// File: rtl/fsk_clk_pkg.sv
// Shared definitions for the FSK shift-clock generator.
//   CNT_W_DEFAULT      : default counter / half-period width
//   IDLE_LEVEL_DEFAULT : default clock_out level when not generating
//   fsk_state_e        : controller states
package fsk_clk_pkg;

  localparam int unsigned CNT_W_DEFAULT      = 12;
  localparam logic        IDLE_LEVEL_DEFAULT = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fsk_state_e;

endpackage

// File: rtl/trigger_sync.sv
// Two-flop synchroniser bank for asynchronous control inputs.
//   clock_in : destination clock
//   reset    : asynchronous active-high reset, flops clear to 0
//   async_in : raw inputs from another clock domain
//   sync_out : inputs retimed to clock_in (2-cycle latency)
module trigger_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/fsk_shift_clock.sv
// Gated square-wave shift-clock generator with two FSK tone registers.
// Tone changes take effect only on a toggle, so the output stays glitch-free
// and phase-continuous; dropping the trigger lets a high phase finish.
// Build option: define FSK_TRIGGER_SYNC_EN to retime trigger_signal and
// tone_sel through 2-flop synchronisers (adds 2 cycles of latency).
//   clock_in       : system clock, rising edge
//   reset          : asynchronous active-high reset
//   trigger_signal : run request (low = stop at next IDLE_LEVEL phase)
//   tone_sel       : selects half_period_0 / half_period_1 at latch points
//   half_period_0  : tone-0 terminal count (half-period = value+1 cycles)
//   half_period_1  : tone-1 terminal count
//   clock_out      : generated shift clock
//   toggle_strobe  : high in the cycle clock_out has just changed
//   tone_active    : tone currently in force
//   busy           : high while generating or draining
module fsk_shift_clock
  import fsk_clk_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEFAULT,
  parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             trigger_signal,
  input  logic             tone_sel,
  input  logic [CNT_W-1:0] half_period_0,
  input  logic [CNT_W-1:0] half_period_1,
  output logic             clock_out,
  output logic             toggle_strobe,
  output logic             tone_active,
  output logic             busy
);

  logic trig;
  logic sel;

`ifdef FSK_TRIGGER_SYNC_EN
  logic [1:0] sync_q;

  trigger_sync #(.WIDTH(2)) u_trigger_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .async_in ({trigger_signal, tone_sel}),
    .sync_out (sync_q)
  );

  assign trig = sync_q[1];
  assign sel  = sync_q[0];
`else
  assign trig = trigger_signal;
  assign sel  = tone_sel;
`endif

  fsk_state_e       state, state_nxt;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic [CNT_W-1:0] limit, limit_nxt;
  logic [CNT_W-1:0] sel_limit;
  logic             level_nxt, strobe_nxt, tone_nxt;
  logic             launch, launch_nxt;
  logic             terminal;

  assign sel_limit = sel ? half_period_1 : half_period_0;
  assign terminal  = (counter == limit);

  // State and output registers
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      counter       <= '0;
      limit         <= '0;
      clock_out     <= IDLE_LEVEL;
      toggle_strobe <= 1'b0;
      tone_active   <= 1'b0;
      busy          <= 1'b0;
      launch        <= 1'b0;
    end else begin
      state         <= state_nxt;
      counter       <= counter_nxt;
      limit         <= limit_nxt;
      clock_out     <= level_nxt;
      toggle_strobe <= strobe_nxt;
      tone_active   <= tone_nxt;
      busy          <= (state_nxt != ST_IDLE);
      launch        <= launch_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    limit_nxt   = limit;
    level_nxt   = clock_out;
    strobe_nxt  = 1'b0;
    tone_nxt    = tone_active;
    launch_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        counter_nxt = '0;
        level_nxt   = IDLE_LEVEL;
        if (trig) begin
          state_nxt  = ST_RUN;
          limit_nxt  = sel_limit;
          tone_nxt   = sel;
          launch_nxt = 1'b1;
        end
      end

      ST_RUN: begin
        if (launch) begin
          // First RUN cycle holds the counter so the first half-phase is limit+2 edges
          if (!trig) state_nxt = ST_IDLE;
        end else if (terminal) begin
          // Latch point: toggle and pick up the currently selected tone
          counter_nxt = '0;
          level_nxt   = ~clock_out;
          strobe_nxt  = 1'b1;
          limit_nxt   = sel_limit;
          tone_nxt    = sel;
          if (!trig) state_nxt = (~clock_out == IDLE_LEVEL) ? ST_IDLE : ST_DRAIN;
        end else if (!trig && (clock_out == IDLE_LEVEL)) begin
          state_nxt   = ST_IDLE;
          counter_nxt = '0;
        end else begin
          counter_nxt = counter + CNT_W'(1);
          if (!trig) state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Limit is frozen here; the only toggle returns to IDLE_LEVEL
        if (terminal) begin
          counter_nxt = '0;
          level_nxt   = ~clock_out;
          strobe_nxt  = 1'b1;
          state_nxt   = trig ? ST_RUN : ST_IDLE;
        end else begin
          counter_nxt = counter + CNT_W'(1);
          if (trig) state_nxt = ST_RUN;
        end
      end

      default: begin
        state_nxt   = ST_IDLE;
        counter_nxt = '0;
        level_nxt   = IDLE_LEVEL;
      end
    endcase
  end

endmodule

// File: tb/tb_fsk_shift_clock.sv
// Self-checking bench for fsk_shift_clock: a countdown-based behavioural model
// is compared against the DUT on every negative clock edge, and directed
// scenarios pin edge counts to hand-computed constants.
module tb_fsk_shift_clock;

  localparam int unsigned CNT_W      = 12;
  localparam logic        IDLE_LEVEL = 1'b0;

  logic             clock_in = 1'b0;
  logic             reset;
  logic             trigger_signal;
  logic             tone_sel;
  logic [CNT_W-1:0] half_period_0;
  logic [CNT_W-1:0] half_period_1;
  logic             clock_out;
  logic             toggle_strobe;
  logic             tone_active;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  fsk_shift_clock #(.CNT_W(CNT_W), .IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clock_in       (clock_in),
    .reset          (reset),
    .trigger_signal (trigger_signal),
    .tone_sel       (tone_sel),
    .half_period_0  (half_period_0),
    .half_period_1  (half_period_1),
    .clock_out      (clock_out),
    .toggle_strobe  (toggle_strobe),
    .tone_active    (tone_active),
    .busy           (busy)
  );

  always #5 clock_in = ~clock_in;

  // Behavioural model: m_left counts the edges remaining until the next toggle
  bit m_busy, m_level, m_drain, m_strobe, m_tone;
  int m_left, m_half;

  always @(posedge clock_in or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_level = IDLE_LEVEL; m_drain = 0; m_strobe = 0; m_tone = 0;
      m_left = 0; m_half = 1;
    end else begin
      m_strobe = 0;
      if (!m_busy) begin
        m_level = IDLE_LEVEL;
        if (trigger_signal) begin
          m_busy  = 1;
          m_drain = 0;
          m_tone  = tone_sel;
          m_half  = int'(tone_sel ? half_period_1 : half_period_0) + 1;
          m_left  = m_half + 1;
        end
      end else if (m_left == 1) begin
        m_level  = !m_level;
        m_strobe = 1;
        if (!m_drain) begin
          m_tone = tone_sel;
          m_half = int'(tone_sel ? half_period_1 : half_period_0) + 1;
        end
        m_left = m_half;
        if (trigger_signal)            m_drain = 0;
        else if (m_level == IDLE_LEVEL) m_busy = 0;
        else                           m_drain = 1;
      end else if (!trigger_signal && m_level == IDLE_LEVEL) begin
        m_busy = 0;
      end else begin
        m_left  = m_left - 1;
        m_drain = !trigger_signal;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock_in) begin
    if (chk_en) begin
      n_cmp++;
      if ({clock_out, toggle_strobe, tone_active, busy} !== {m_level, m_strobe, m_tone, m_busy}) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t: dut clk/strb/tone/busy=%b%b%b%b model=%b%b%b%b", $time,
                 clock_out, toggle_strobe, tone_active, busy, m_level, m_strobe, m_tone, m_busy);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edges (sampled 1ns after each) until clock_out changes, bounded by max_edges
  task automatic edges_until_change(input int max_edges, output int n);
    logic start_v;
    start_v = clock_out;
    n = 0;
    while (n < max_edges) begin
      @(posedge clock_in); #1;
      n++;
      if (clock_out !== start_v) break;
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clock_in);
    #1;
  endtask

  initial begin
    int n;
    int cnt;
    reset = 1'b1; trigger_signal = 1'b0; tone_sel = 1'b0;
    half_period_0 = '0; half_period_1 = '0;
    repeat (3) @(posedge clock_in);
    #1;
    check("reset_clock_out", clock_out, 0);
    check("reset_busy", busy, 0);
    check("reset_strobe", toggle_strobe, 0);
    check("reset_tone", tone_active, 0);
    chk_en = 1'b1;
    reset  = 1'b0;
    step(3);

    // Tone 0, 319: first rise 321 edges after the sampling edge, then 320/320
    half_period_0 = 12'd319; half_period_1 = 12'd159; tone_sel = 0; trigger_signal = 1;
    step(1);
    check("busy_after_start", busy, 1);
    edges_until_change(5000, n); check("first_rise_edges", n, 321);
    check("first_rise_level", clock_out, 1);
    check("first_rise_strobe", toggle_strobe, 1);
    edges_until_change(5000, n); check("low_phase_edges", n, 320);
    edges_until_change(5000, n); check("high_phase_edges", n, 320);

    // Tone switch mid-phase: current half completes, then 160-cycle halves
    step(100);
    tone_sel = 1;
    edges_until_change(5000, n); check("switch_complete_edges", n, 220);
    check("tone_after_switch", tone_active, 1);
    edges_until_change(5000, n); check("tone1_half_a", n, 160);
    edges_until_change(5000, n); check("tone1_half_b", n, 160);
    tone_sel = 0;
    edges_until_change(5000, n); check("tone1_half_c", n, 160);
    check("tone_back_to_0", tone_active, 0);

    // Trigger dropped 10 cycles into a high phase: finishes 310 later
    step(10);
    trigger_signal = 0;
    step(1);
    check("busy_in_drain", busy, 1);
    edges_until_change(5000, n); check("drain_fall_edges", n, 309);
    check("idle_busy_after_drain", busy, 0);
    check("idle_level_after_drain", clock_out, 0);

    // Re-assert trigger during DRAIN: stays on the 320-cycle grid
    trigger_signal = 1;
    step(1);
    edges_until_change(5000, n); check("restart_rise_edges", n, 321);
    step(10);
    trigger_signal = 0;
    step(50);
    trigger_signal = 1;
    edges_until_change(5000, n); check("redrain_fall_edges", n, 260);
    edges_until_change(5000, n); check("redrain_rise_edges", n, 320);
    trigger_signal = 0;
    edges_until_change(5000, n); check("stop_fall_edges", n, 320);
    step(1);
    check("stopped_busy", busy, 0);

    // limit 0: toggles every cycle, strobe continuously high
    half_period_0 = 12'd0; trigger_signal = 1;
    step(3);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (toggle_strobe === 1'b1) cnt++;
      step(1);
    end
    check("limit0_strobe_count", cnt, 20);
    trigger_signal = 0;
    step(3);
    check("limit0_stopped", busy, 0);

    // Maximum half-period
    half_period_0 = 12'd4095; trigger_signal = 1;
    step(1);
    edges_until_change(10000, n); check("max_first_rise", n, 4097);
    edges_until_change(10000, n); check("max_half", n, 4096);
    edges_until_change(10000, n); check("max_half_2", n, 4096);

    // Async reset mid-RUN with clock_out high
    step(5);
    check("pre_reset_high", clock_out, 1);
    #1 reset = 1;
    #1;
    check("async_reset_clock_out", clock_out, 0);
    check("async_reset_busy", busy, 0);
    trigger_signal = 0;
    step(2);
    reset = 0;
    step(20);
    check("idle_after_reset", busy, 0);
    check("idle_level_after_reset", clock_out, 0);

    // Randomised traffic against the model
    half_period_0 = 12'd3; half_period_1 = 12'd1;
    for (int i = 0; i < 15000; i++) begin
      @(posedge clock_in); #1;
      reset = 0;
      if ($urandom_range(39, 0) == 0) trigger_signal = ~trigger_signal;
      if ($urandom_range(19, 0) == 0) tone_sel = ~tone_sel;
      if ($urandom_range(29, 0) == 0)
        half_period_0 = CNT_W'($urandom_range(($urandom_range(3, 0) == 0) ? 63 : 15, 0));
      if ($urandom_range(29, 0) == 0)
        half_period_1 = CNT_W'($urandom_range(15, 0));
      if ($urandom_range(2999, 0) == 0) reset = 1;
    end
    reset = 0;
    trigger_signal = 0;
    step(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
